// File: rtl/user_input_irq_pkg.sv
// Shared constants and helpers for the user_input_irq block.
// Optional feature macro: USER_INPUT_IRQ_DEBOUNCE_EN (per-bit debounce counters).
package user_input_irq_pkg;

    // Avalon-MM word addresses
    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd1;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd2;
    localparam logic [2:0] ADDR_RISE_EN  = 3'd3;
    localparam logic [2:0] ADDR_FALL_EN  = 3'd4;
    localparam logic [2:0] ADDR_INFO     = 3'd5;

    // INFO register field offsets
    localparam int INFO_KEYS_LSB     = 0;
    localparam int INFO_SWITCHES_LSB = 8;
    localparam int INFO_DEBOUNCE_BIT = 16;

`ifdef USER_INPUT_IRQ_DEBOUNCE_EN
    localparam bit DEBOUNCE_EN = 1'b1;
`else
    localparam bit DEBOUNCE_EN = 1'b0;
`endif

    // Bits needed to hold values 0 .. value-1
    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << width) < value) width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/user_input_debounce.sv
// One-bit input conditioner: 2-FF synchroniser, optional debounce counter
// (USER_INPUT_IRQ_DEBOUNCE_EN), and registered one-cycle rise/fall pulses
// that coincide with the first cycle the stable value shows the new level.
module user_input_debounce
    import user_input_irq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o
);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_cfg
        $error("user_input_debounce: DEBOUNCE_CYCLES must be at least 2");
    end

    logic [1:0] sync_q, sync_d;
    logic       stable_cur;   // current accepted level
    logic       stable_nxt;   // level the stable value takes after this edge
    logic       rise_q, rise_d, fall_q, fall_d;

    // Synchroniser shift and edge detection on the accepted level
    always_comb begin
        sync_d = {sync_q[0], raw_i};
        rise_d = stable_nxt & ~stable_cur;
        fall_d = ~stable_nxt & stable_cur;
    end

    // Synchroniser and pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments in clocked blocks so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            sync_q <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

`ifdef USER_INPUT_IRQ_DEBOUNCE_EN
    localparam int                CNT_W    = clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;

    // Count consecutive cycles the synchronised level differs from stable
    always_comb begin
        // NOTE: defaults first so every path assigns, which keeps this
        // block free of inferred latches.
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync_q[1] != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Debounce counter and accepted level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_cur = stable_q;
    assign stable_nxt = stable_d;
`else
    assign stable_cur = sync_q[1];
    assign stable_nxt = sync_q[0];
`endif

    assign stable_o = stable_cur;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;

endmodule

// File: rtl/user_input_irq.sv
// Key/switch input block for the HPS: conditions each input, latches
// selected edges into a write-1-to-clear register and raises a masked
// level IRQ. Avalon-MM slave with fixed read latency 1.
// Optional feature macro: USER_INPUT_IRQ_DEBOUNCE_EN.
module user_input_irq
    import user_input_irq_pkg::*;
#(
    parameter int N_KEYS          = 4,
    parameter int N_SWITCHES      = 4,
    parameter bit KEY_ACTIVE_LOW  = 1'b1,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                                          clk_clk,
    input  logic                                          reset_reset_n,
    input  logic [N_KEYS-1:0]                             user_input_keys,
    input  logic [((N_SWITCHES > 0) ? N_SWITCHES : 1)-1:0] user_input_switches,
    input  logic [2:0]                                    avs_address,
    input  logic                                          avs_read,
    input  logic                                          avs_write,
    input  logic [31:0]                                   avs_writedata,
    output logic [31:0]                                   avs_readdata,
    output logic                                          irq
);

    localparam int N = N_KEYS + N_SWITCHES;

    logic [N_KEYS-1:0] keys_pos;
    logic [N-1:0]      in_vec, stable_vec, rise_vec, fall_vec;
    logic [N-1:0]      mask_q, mask_d, cap_q, cap_d;
    logic [N-1:0]      rise_en_q, rise_en_d, fall_en_q, fall_en_d;
    logic [N-1:0]      wdata_n, w1c;
    logic [31:0]       rd_q, rd_d;
    logic              irq_q, irq_d;

    assign keys_pos = KEY_ACTIVE_LOW ? ~user_input_keys : user_input_keys;

    if (N_SWITCHES > 0) begin : g_switches
        assign in_vec = {user_input_switches, keys_pos};
    end else begin : g_no_switches
        logic unused_switches;
        assign unused_switches = user_input_switches[0];
        assign in_vec = keys_pos;
    end

    if (N < 32) begin : g_wdata_unused
        logic unused_wdata;
        assign unused_wdata = ^avs_writedata[31:N];
    end

    for (genvar i = 0; i < N; i++) begin : g_bit
        user_input_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk     (clk_clk),
            .rst_n   (reset_reset_n),
            .raw_i   (in_vec[i]),
            .stable_o(stable_vec[i]),
            .rise_o  (rise_vec[i]),
            .fall_o  (fall_vec[i])
        );
    end

    // Register writes, edge capture (set beats clear) and IRQ level
    always_comb begin
        wdata_n   = avs_writedata[N-1:0];
        mask_d    = mask_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        w1c       = '0;
        if (avs_write) begin
            case (avs_address)
                ADDR_IRQ_MASK: mask_d    = wdata_n;
                ADDR_EDGE_CAP: w1c       = wdata_n;
                ADDR_RISE_EN:  rise_en_d = wdata_n;
                ADDR_FALL_EN:  fall_en_d = wdata_n;
                default: ;
            endcase
        end
        cap_d = (cap_q & ~w1c) | (rise_vec & rise_en_q) | (fall_vec & fall_en_q);
        irq_d = |(cap_q & mask_q);
    end

    // Read mux; readdata holds when no read is issued
    always_comb begin
        rd_d = rd_q;
        if (avs_read) begin
            rd_d = '0;
            case (avs_address)
                ADDR_DATA:     rd_d[N-1:0] = stable_vec;
                ADDR_IRQ_MASK: rd_d[N-1:0] = mask_q;
                ADDR_EDGE_CAP: rd_d[N-1:0] = cap_q;
                ADDR_RISE_EN:  rd_d[N-1:0] = rise_en_q;
                ADDR_FALL_EN:  rd_d[N-1:0] = fall_en_q;
                ADDR_INFO: begin
                    rd_d[INFO_KEYS_LSB +: 8]     = 8'(N_KEYS);
                    rd_d[INFO_SWITCHES_LSB +: 8] = 8'(N_SWITCHES);
                    rd_d[INFO_DEBOUNCE_BIT]      = DEBOUNCE_EN;
                end
                default: ;
            endcase
        end
    end

    // Control/status registers
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            mask_q    <= '0;
            cap_q     <= '0;
            rise_en_q <= '1;
            fall_en_q <= '0;
            rd_q      <= '0;
            irq_q     <= 1'b0;
        end else begin
            mask_q    <= mask_d;
            cap_q     <= cap_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            rd_q      <= rd_d;
            irq_q     <= irq_d;
        end
    end

    assign avs_readdata = rd_q;
    assign irq          = irq_q;

endmodule
